// File: rtl/octa16_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : octa16_mem_loader
//  Purpose  : Host-side loader for the Octa16 external data-memory port.
//             Packs a little-endian byte stream into 16-bit words, writes
//             them at incrementing addresses from 0, then optionally reads
//             every location back and checks the low byte.
//  Ports    : clk, reset (async, active-low)
//             start/word_count   - load request, count sampled on start
//             byte_in/byte_valid/byte_ready - byte stream handshake
//             Ext_MemWrite/Ext_WriteData/Ext_DataAdr - write port
//             DataAddr/dIn       - readback port
//             busy/done/error/err_addr - status
//  Revision : 1.0 - initial release
// ============================================================================
module octa16_mem_loader #(
   parameter int ADDR_W    = 4,
   parameter int DEPTH     = 16,
   parameter int READ_LAT  = 1,
   parameter int VERIFY_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              Ext_MemWrite,
   output logic [15:0]       Ext_WriteData,
   output logic [ADDR_W-1:0] Ext_DataAdr,
   output logic [ADDR_W-1:0] DataAddr,
   input  logic [7:0]        dIn,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GET_LO = 3'd1,
      S_GET_HI = 3'd2,
      S_WRITE  = 3'd3,
      S_VSET   = 3'd4,
      S_VWAIT  = 3'd5,
      S_VCMP   = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
   // Last value of lat_cnt in VWAIT; only meaningful when READ_LAT >= 2.
   localparam logic [1:0]      WAIT_LAST = 2'(READ_LAT - 2);

   state_t            state, state_nx;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] vaddr;
   logic [1:0]        lat_cnt;
   logic [7:0]        word_lo;
   logic [7:0]        shadow [DEPTH];

   logic              count_ok;
   logic [ADDR_W:0]   count_m1;
   logic              last_addr;
   logic              last_vaddr;
   logic              mismatch;

   assign count_ok   = (word_count != '0) && (word_count <= DEPTH_C);
   assign count_m1   = count - {{ADDR_W{1'b0}}, 1'b1};
   // Termination is by comparison with count-1, so a full-depth load stops
   // at DEPTH-1 and the address counter never wraps into a second pass.
   assign last_addr  = ({1'b0, addr}  == count_m1);
   assign last_vaddr = ({1'b0, vaddr} == count_m1);
   assign mismatch   = (dIn != shadow[vaddr]);

   // The readback address is the verify pointer itself.
   assign DataAddr   = vaddr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      byte_ready   = 1'b0;
      Ext_MemWrite = 1'b0;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && count_ok) state_nx = S_GET_LO;
         end
         S_GET_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = S_GET_HI;
         end
         S_GET_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = S_WRITE;
         end
         S_WRITE: begin
            Ext_MemWrite = 1'b1;
            if (last_addr) state_nx = (VERIFY_EN != 0) ? S_VSET : S_DONE;
            else           state_nx = S_GET_LO;
         end
         S_VSET: begin
            // dIn is valid READ_LAT cycles after DataAddr changes; with a
            // single-cycle latency the wait state is skipped entirely.
            state_nx = (READ_LAT > 1) ? S_VWAIT : S_VCMP;
         end
         S_VWAIT: begin
            if (lat_cnt == WAIT_LAST) state_nx = S_VCMP;
         end
         S_VCMP: begin
            if (mismatch || last_vaddr) state_nx = S_DONE;
            else                        state_nx = S_VSET;
         end
         S_DONE: begin
            done     = ~error;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count         <= '0;
         addr          <= '0;
         vaddr         <= '0;
         lat_cnt       <= '0;
         word_lo       <= '0;
         Ext_WriteData <= '0;
         Ext_DataAdr   <= '0;
         busy          <= 1'b0;
         error         <= 1'b0;
         err_addr      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // A rejected start still produces a one-cycle busy pulse.
               busy <= start;
               if (start) begin
                  err_addr <= '0;
                  if (count_ok) begin
                     count <= word_count;
                     addr  <= '0;
                     vaddr <= '0;
                     error <= 1'b0;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            S_GET_LO: begin
               if (byte_valid) word_lo <= byte_in;
            end
            S_GET_HI: begin
               // Write bus is loaded here so it is stable for the whole
               // WRITE cycle and holds afterwards.
               if (byte_valid) begin
                  Ext_WriteData <= {byte_in, word_lo};
                  Ext_DataAdr   <= addr;
               end
            end
            S_WRITE: begin
               if (!last_addr) addr <= addr + ADDR_W'(1);
            end
            S_VSET: begin
               lat_cnt <= '0;
            end
            S_VWAIT: begin
               lat_cnt <= lat_cnt + 2'd1;
            end
            S_VCMP: begin
               if (mismatch) begin
                  error    <= 1'b1;
                  err_addr <= vaddr;
               end else if (!last_vaddr) begin
                  vaddr <= vaddr + ADDR_W'(1);
               end
            end
            S_DONE: begin
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Shadow of the low bytes for readback comparison; contents after reset
   // are irrelevant because every entry is rewritten before it is checked.
   always_ff @(posedge clk) begin
      if (state == S_GET_LO && byte_valid) shadow[addr] <= byte_in;
   end

endmodule
`default_nettype wire

// File: tb/tb_octa16_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_octa16_mem_loader
//  Purpose  : Directed self-checking bench for octa16_mem_loader with a
//             behavioural Octa16 data memory (1-cycle registered readback).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_octa16_mem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  word_count;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        Ext_MemWrite;
   logic [15:0] Ext_WriteData;
   logic [3:0]  Ext_DataAdr;
   logic [3:0]  DataAddr;
   logic [7:0]  dIn;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  err_addr;

   int n_assert = 0;
   int n_fail   = 0;

   octa16_mem_loader dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData),
      .Ext_DataAdr(Ext_DataAdr), .DataAddr(DataAddr), .dIn(dIn),
      .busy(busy), .done(done), .error(error), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   // Memory model with optional forced readback corruption.
   logic [15:0] mem [16];
   logic        force_en;
   logic [3:0]  force_addr;

   always @(posedge clk) begin
      if (Ext_MemWrite) mem[Ext_DataAdr] <= Ext_WriteData;
      dIn <= (force_en && DataAddr == force_addr) ? 8'hFF : mem[DataAddr][7:0];
   end

   // Monitor: samples the previous cycle's outputs at the rising edge.
   logic [3:0]  wlog_a [64];
   logic [15:0] wlog_d [64];
   int          wn = 0;
   int          done_cnt = 0;
   int          rdy_cnt = 0;
   int          dbl_we = 0;
   logic        we_prev = 1'b0;
   logic [15:0] seen_da = '0;

   always @(posedge clk) begin
      if (Ext_MemWrite) begin
         wlog_a[wn] <= Ext_DataAdr;
         wlog_d[wn] <= Ext_WriteData;
         wn <= wn + 1;
      end
      if (we_prev && Ext_MemWrite) dbl_we <= dbl_we + 1;
      we_prev <= Ext_MemWrite;
      if (done) done_cnt <= done_cnt + 1;
      if (byte_ready) rdy_cnt <= rdy_cnt + 1;
      if (start)     seen_da <= '0;
      else if (busy) seen_da <= seen_da | (16'h1 << DataAddr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_load(input logic [4:0] c);
      word_count = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      word_count = 5'd3;   // later changes must have no effect
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      byte_in = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("byte_ready_seen", byte_ready, 1);
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   int w0, d0, r0;
   logic [7:0] lo, hi;

   initial begin
      reset = 1'b0; start = 1'b0; word_count = '0; byte_in = '0;
      byte_valid = 1'b0; force_en = 1'b0; force_addr = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_we",     Ext_MemWrite, 0);
      chk("rst_wdata",  Ext_WriteData, 0);
      chk("rst_wadr",   Ext_DataAdr, 0);
      chk("rst_daddr",  DataAddr, 0);
      chk("rst_busy",   busy, 0);
      chk("rst_done",   done, 0);
      chk("rst_error",  error, 0);
      chk("rst_erradr", err_addr, 0);
      chk("rst_ready",  byte_ready, 0);
      reset = 1'b1;
      @(negedge clk);

      // 1: count=2, back-to-back bytes
      w0 = wn; d0 = done_cnt;
      start_load(5'd2);
      chk("t1_busy", busy, 1);
      send_byte(8'hCD, 0); send_byte(8'hAB, 0);
      send_byte(8'h34, 0); send_byte(8'h12, 0);
      wait_idle("t1_idle");
      chk("t1_nwr",   wn - w0, 2);
      chk("t1_a0",    wlog_a[w0], 0);
      chk("t1_d0",    wlog_d[w0], 16'hABCD);
      chk("t1_a1",    wlog_a[w0+1], 1);
      chk("t1_d1",    wlog_d[w0+1], 16'h1234);
      chk("t1_done",  done_cnt - d0, 1);
      chk("t1_error", error, 0);

      // 2: count=4 with 3-cycle gaps between bytes
      w0 = wn; d0 = done_cnt;
      start_load(5'd4);
      send_byte(8'hCD, 3); send_byte(8'hAB, 3);
      send_byte(8'h34, 3); send_byte(8'h12, 3);
      send_byte(8'h78, 3); send_byte(8'h56, 3);
      send_byte(8'hBC, 3); send_byte(8'h9A, 3);
      wait_idle("t2_idle");
      chk("t2_nwr",  wn - w0, 4);
      chk("t2_d2",   wlog_d[w0+2], 16'h5678);
      chk("t2_a3",   wlog_a[w0+3], 3);
      chk("t2_d3",   wlog_d[w0+3], 16'h9ABC);
      chk("t2_done", done_cnt - d0, 1);
      chk("t2_dblwe", dbl_we, 0);

      // 3: full depth
      w0 = wn; d0 = done_cnt;
      start_load(5'd16);
      for (int i = 0; i < 16; i++) begin
         lo = 8'(i) ^ 8'hA5;
         hi = 8'(i) + 8'h10;
         send_byte(lo, 0);
         send_byte(hi, 0);
      end
      wait_idle("t3_idle");
      repeat (5) @(negedge clk);
      chk("t3_nwr", wn - w0, 16);
      for (int i = 0; i < 16; i++) begin
         chk("t3_addr", wlog_a[w0+i], 32'(i));
         chk("t3_data", wlog_d[w0+i], {8'(i) + 8'h10, 8'(i) ^ 8'hA5});
      end
      chk("t3_sweep",  seen_da, 16'hFFFF);
      chk("t3_lastad", Ext_DataAdr, 4'hF);
      chk("t3_hold",   Ext_WriteData, 16'h1FAA);
      chk("t3_done",   done_cnt - d0, 1);
      chk("t3_ready",  byte_ready, 0);
      chk("t3_dblwe",  dbl_we, 0);

      // 4: corrupted readback at address 1
      w0 = wn; d0 = done_cnt;
      force_en = 1'b1; force_addr = 4'd1;
      start_load(5'd2);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      send_byte(8'h33, 0); send_byte(8'h44, 0);
      wait_idle("t4_idle");
      force_en = 1'b0;
      chk("t4_nwr",    wn - w0, 2);
      chk("t4_d1",     wlog_d[w0+1], 16'h4433);
      chk("t4_error",  error, 1);
      chk("t4_erradr", err_addr, 1);
      chk("t4_nodone", done_cnt - d0, 0);

      // 5: bad counts
      w0 = wn; d0 = done_cnt; r0 = rdy_cnt;
      start_load(5'd0);
      chk("t5a_busy",   busy, 1);
      chk("t5a_error",  error, 1);
      chk("t5a_erradr", err_addr, 0);
      @(negedge clk);
      chk("t5a_busy0",  busy, 0);
      start_load(5'd17);
      chk("t5b_busy",   busy, 1);
      chk("t5b_error",  error, 1);
      chk("t5b_erradr", err_addr, 0);
      repeat (4) @(negedge clk);
      chk("t5_busy0",  busy, 0);
      chk("t5_nwr",    wn - w0, 0);
      chk("t5_ready",  rdy_cnt - r0, 0);
      chk("t5_nodone", done_cnt - d0, 0);

      // 6: reset after third byte of a count=2 load
      w0 = wn; d0 = done_cnt;
      start_load(5'd2);
      chk("t6_errclr", error, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
      reset = 1'b0;
      #1;
      chk("t6_we",     Ext_MemWrite, 0);
      chk("t6_wdata",  Ext_WriteData, 0);
      chk("t6_wadr",   Ext_DataAdr, 0);
      chk("t6_daddr",  DataAddr, 0);
      chk("t6_busy",   busy, 0);
      chk("t6_ready",  byte_ready, 0);
      chk("t6_erradr", err_addr, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_nwr", wn - w0, 1);
      w0 = wn;
      start_load(5'd1);
      send_byte(8'h5A, 0); send_byte(8'hA5, 0);
      wait_idle("t6_idle");
      chk("t6r_nwr",  wn - w0, 1);
      chk("t6r_a0",   wlog_a[w0], 0);
      chk("t6r_d0",   wlog_d[w0], 16'hA55A);
      chk("t6r_done", done_cnt - d0, 1);
      chk("t6r_err",  error, 0);
      chk("t6_dblwe", dbl_we, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
